fifo_rd_ptr_empty: RTL and testbench
====================================

Name: fifo_rd_ptr_empty

Overview:
Read-side pointer and status block of the async FIFO, running in the read clock domain. It consumes the write-pointer Gray code after the two-flop synchronizer has brought it into the read domain. It produces the read RAM address, the read Gray pointer (sent back to the write domain through a synchronizer), and the empty, almost-empty and fill-level status.

Parameters:
ADDR_WIDTH, 3, RAM address width; FIFO depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
ALMOST_EMPTY_TH, 1, almost_empty asserts when fill level <= this value (legal range 0..2^ADDR_WIDTH-1)

Ports:
clk  input  1  read-domain clock
rst_n  input  1  asynchronous active-low reset
rd_en  input  1  read request from the consumer
rq2_wptr  input  ADDR_WIDTH+1  write Gray pointer, already synchronized into the read domain
raddr  output  ADDR_WIDTH  read address to the FIFO RAM
rptr  output  ADDR_WIDTH+1  registered read Gray pointer, to the write-domain synchronizer
empty  output  1  FIFO empty, registered
almost_empty  output  1  fill level <= ALMOST_EMPTY_TH, registered
rd_level  output  ADDR_WIDTH+1  words available as seen by the read side, registered

Behaviour:
- Reset: asynchronous and active-low. rst_n=0 clears all state immediately, without waiting for a clock edge.
  - Binary counter rbin=0, rptr=0, raddr=0, rd_level=0, empty=1, almost_empty=1.
  - Release of reset is synchronous to the next clk edge.
- Read qualification: rd_inc = rd_en & ~empty.
  - A read while empty is ignored. No state changes.
- Next-state logic:
  - rbin_next = rbin + rd_inc, modulo 2^(ADDR_WIDTH+1). Wrap-around is natural.
  - rgray_next = (rbin_next >> 1) ^ rbin_next.
- Registers updated on posedge clk:
  - rbin <= rbin_next
  - rptr <= rgray_next
  - empty <= (rgray_next == rq2_wptr), a full-width compare that includes the wrap MSB
- raddr = rbin[ADDR_WIDTH-1:0], combinational from the register. Valid in the same cycle as the accepted rd_en; the RAM read data is associated with that address.
- rptr comes straight from a flop, so exactly one bit toggles per accepted read. No combinational logic is allowed between the flop and the port.
- Fill level:
  - wbin_s = gray-to-binary of rq2_wptr, combinational XOR prefix from the MSB down.
  - level_next = (wbin_s - rbin_next) modulo 2^(ADDR_WIDTH+1).
  - rd_level <= level_next.
  - almost_empty <= (level_next <= ALMOST_EMPTY_TH).
- Latency: a change on rq2_wptr is reflected in empty, rd_level and almost_empty one clk edge later. An accepted read is reflected in rptr, raddr and the status outputs at the same edge.
- Simultaneous events: if rq2_wptr advances and a read is accepted in the same cycle, status is computed from rbin_next and the new rq2_wptr. No read or write is lost.
- Empty is pessimistic. Because of synchronizer delay it may stay asserted after the writer has written. It must never deassert while the FIFO is truly empty.
- Level bound: with a correct writer, level_next never exceeds 2^ADDR_WIDTH. The block does not clamp.
- Wrap:
  - raddr wraps from 2^ADDR_WIDTH-1 to 0.
  - rptr wraps from gray(2^(ADDR_WIDTH+1)-1) to 0.
  - empty remains correct across the wrap because of the MSB compare.

Optional Feature:
RD_UNDERFLOW_FLAG_EN
- Defined: adds output port rd_underflow (1 bit). It is set at the clk edge that samples rd_en=1 while empty=1, and stays set (sticky) until rst_n=0. Reset value is 0. Pointer behaviour is unchanged.
- Undefined: the port and its logic are absent. Reads while empty are silently ignored.

Test Plan:
(ADDR_WIDTH=3, ALMOST_EMPTY_TH=1)
- Reset: assert rst_n=0 mid-cycle with no clock edge -> rptr=0, raddr=0, rd_level=0, empty=1 and almost_empty=1 immediately.
- Fill and drain:
  - Drive rq2_wptr=4'b0010 (bin 3) -> next edge gives empty=0, rd_level=3, almost_empty=0.
  - Then rd_en=1 for 3 cycles -> raddr 0,1,2, then rptr=4'b0010, empty=1, rd_level=0.
- Underflow: rd_en=1 for 4 cycles while empty -> rptr and raddr unchanged, empty stays 1. With RD_UNDERFLOW_FLAG_EN, rd_underflow=1 after the first edge and stays 1.
- Almost-empty threshold: rd_level=2, one read -> rd_level=1 and almost_empty=1 at the same edge; next read -> empty=1.
- Wrap: a writer model keeps the write pointer ahead; 16 accepted reads ->
  - After 8 reads: rptr=4'b1100, raddr=0.
  - After 16 reads: rptr=0.
  - Exactly one rptr bit changes per read; empty is correct throughout.
- Simultaneous events and reset mid-operation:
  - A read is accepted in the same cycle rq2_wptr advances by 1 -> rd_level unchanged.
  - rst_n=0 at level 5 -> all outputs return to reset values asynchronously.
  - After reset is released, reading resumes from raddr=0.

Source files
------------

// File: rtl/fifo_rd_ptr_empty_if.sv
// Read-side port bundle of the async FIFO: consumer request, synchronized write pointer,
// read address/pointer and status. RD_UNDERFLOW_FLAG_EN adds the sticky rd_underflow flag.
interface fifo_rd_ptr_empty_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  rd_en;
    logic [ADDR_WIDTH:0]   rq2_wptr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   rd_level;
`ifdef RD_UNDERFLOW_FLAG_EN
    logic                  rd_underflow;
`endif

`ifdef RD_UNDERFLOW_FLAG_EN
    modport master (
        output rd_en, rq2_wptr,
        input  raddr, rptr, empty, almost_empty, rd_level, rd_underflow
    );
    modport slave (
        input  rd_en, rq2_wptr,
        output raddr, rptr, empty, almost_empty, rd_level, rd_underflow
    );
`else
    modport master (
        output rd_en, rq2_wptr,
        input  raddr, rptr, empty, almost_empty, rd_level
    );
    modport slave (
        input  rd_en, rq2_wptr,
        output raddr, rptr, empty, almost_empty, rd_level
    );
`endif
endinterface

// File: rtl/fifo_rd_ptr_empty.sv
// Read-domain pointer and status block of the async FIFO (binary/Gray read pointer, empty,
// almost-empty, fill level). Optional macro RD_UNDERFLOW_FLAG_EN adds a sticky underflow flag.
module fifo_rd_ptr_empty #(
    parameter int ADDR_WIDTH      = 3,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_rd_ptr_empty_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_TH  = PW'(ALMOST_EMPTY_TH);
    localparam logic [PW-1:0] PTR_ZERO = '0;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // MSB-down XOR prefix turns the synchronized Gray pointer back into binary
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] r_rbin;
    logic [PW-1:0] r_rptr;
    logic          r_empty;
    logic          r_almost_empty;
    logic [PW-1:0] r_rd_level;

    logic          w_rd_inc;
    logic [PW-1:0] w_rbin_next;
    logic [PW-1:0] w_rgray_next;
    logic [PW-1:0] w_wbin;
    logic [PW-1:0] w_level_next;
    logic          w_empty_next;
    logic          w_almost_empty_next;

    // Next-state computation: qualified read, next pointers and status
    always_comb begin
        w_rd_inc            = 1'b0;
        w_rbin_next         = r_rbin;
        w_rgray_next        = r_rptr;
        w_wbin              = gray2bin(bus.rq2_wptr);
        w_level_next        = PTR_ZERO;
        w_empty_next        = 1'b1;
        w_almost_empty_next = 1'b1;

        if (bus.rd_en && !r_empty) begin
            w_rd_inc = 1'b1;
        end else begin
            w_rd_inc = 1'b0;
        end

        w_rbin_next  = r_rbin + {{ADDR_WIDTH{1'b0}}, w_rd_inc};
        w_rgray_next = bin2gray(w_rbin_next);
        // Full-width compare: the MSB tells a full wrap apart from empty
        w_empty_next = (w_rgray_next == bus.rq2_wptr);
        w_level_next = w_wbin - w_rbin_next;
        w_almost_empty_next = (w_level_next <= AE_TH);
    end

    // Pointer and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rbin         <= PTR_ZERO;
            r_rptr         <= PTR_ZERO;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rd_level     <= PTR_ZERO;
        end else begin
            r_rbin         <= w_rbin_next;
            r_rptr         <= w_rgray_next;
            r_empty        <= w_empty_next;
            r_almost_empty <= w_almost_empty_next;
            r_rd_level     <= w_level_next;
        end
    end

`ifdef RD_UNDERFLOW_FLAG_EN
    logic r_rd_underflow;

    // Sticky flag for a read request seen while empty; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_underflow <= 1'b0;
        end else if (bus.rd_en && r_empty) begin
            r_rd_underflow <= 1'b1;
        end else begin
            r_rd_underflow <= r_rd_underflow;
        end
    end

    assign bus.rd_underflow = r_rd_underflow;
`endif

    assign bus.raddr        = r_rbin[ADDR_WIDTH-1:0];
    assign bus.rptr         = r_rptr;
    assign bus.empty        = r_empty;
    assign bus.almost_empty = r_almost_empty;
    assign bus.rd_level     = r_rd_level;

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
// Scoreboard bench for fifo_rd_ptr_empty (ADDR_WIDTH=3, ALMOST_EMPTY_TH=1); a counting
// writer/reader model predicts outputs, which are queued and compared after each edge.
module tb_fifo_rd_ptr_empty;
    logic clk;
    logic rst_n;

    fifo_rd_ptr_empty_if #(.ADDR_WIDTH(3)) bus ();

    fifo_rd_ptr_empty #(.ADDR_WIDTH(3), .ALMOST_EMPTY_TH(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] raddr;
        logic [3:0] rptr;
        logic       empty;
        logic       ae;
        logic [3:0] lvl;
        logic       uf;
    } exp_t;

    exp_t       sb_q[$];
    int         n_total = 0;
    int         n_bad   = 0;
    logic [3:0] m_r;
    logic [3:0] w_cnt;
    logic       m_empty;
    logic       m_uf;

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check_val("rst_raddr", 32'(bus.raddr), 32'd0);
        check_val("rst_rptr", 32'(bus.rptr), 32'd0);
        check_val("rst_level", 32'(bus.rd_level), 32'd0);
        check_val("rst_empty", 32'(bus.empty), 32'd1);
        check_val("rst_ae", 32'(bus.almost_empty), 32'd1);
`ifdef RD_UNDERFLOW_FLAG_EN
        check_val("rst_uf", 32'(bus.rd_underflow), 32'd0);
`endif
    endtask

    // Assert reset between clock edges and check outputs before any edge arrives
    task automatic do_reset();
        #2;
        rst_n        = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rq2_wptr = 4'd0;
        m_r = 4'd0; w_cnt = 4'd0; m_empty = 1'b1; m_uf = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, predict and queue outputs, then pop and compare after the edge
    task automatic step(input logic rd, input logic [3:0] wcnt_new);
        exp_t       e;
        exp_t       got;
        logic       inc;
        logic [3:0] prev_rptr;
        w_cnt        = wcnt_new;
        bus.rq2_wptr = to_gray(w_cnt);
        bus.rd_en    = rd;
        prev_rptr    = bus.rptr;
        inc   = rd && !m_empty;
        m_uf  = m_uf || (rd && m_empty);
        m_r   = m_r + {3'd0, inc};
        e.lvl   = w_cnt - m_r;
        m_empty = (e.lvl == 4'd0);
        e.raddr = m_r[2:0];
        e.rptr  = to_gray(m_r);
        e.empty = m_empty;
        e.ae    = (e.lvl <= 4'd1);
        e.uf    = m_uf;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_val("raddr", 32'(bus.raddr), 32'(got.raddr));
        check_val("rptr", 32'(bus.rptr), 32'(got.rptr));
        check_val("empty", 32'(bus.empty), 32'(got.empty));
        check_val("almost_empty", 32'(bus.almost_empty), 32'(got.ae));
        check_val("rd_level", 32'(bus.rd_level), 32'(got.lvl));
`ifdef RD_UNDERFLOW_FLAG_EN
        check_val("rd_underflow", 32'(bus.rd_underflow), 32'(got.uf));
`endif
        if (inc) begin
            check_val("rptr_onebit", 32'($countones(prev_rptr ^ bus.rptr)), 32'd1);
        end
        bus.rd_en = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b1;
        bus.rd_en    = 1'b0;
        bus.rq2_wptr = 4'd0;
        do_reset();

        // Fill to 3 then drain
        step(1'b0, 4'd3);
        check_val("fill_level", 32'(bus.rd_level), 32'd3);
        check_val("fill_empty", 32'(bus.empty), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_val("drain_raddr", 32'(bus.raddr), 32'(i));
            step(1'b1, 4'd3);
        end
        check_val("drain_rptr", 32'(bus.rptr), 32'b0010);
        check_val("drain_empty", 32'(bus.empty), 32'd1);

        // Reads while empty
        for (int i = 0; i < 4; i++) step(1'b1, 4'd3);
        check_val("uf_rptr", 32'(bus.rptr), 32'b0010);
        check_val("uf_raddr", 32'(bus.raddr), 32'd3);

        // Almost-empty threshold
        step(1'b0, 4'd5);
        step(1'b1, 4'd5);
        check_val("th_level", 32'(bus.rd_level), 32'd1);
        check_val("th_ae", 32'(bus.almost_empty), 32'd1);
        step(1'b1, 4'd5);
        check_val("th_empty", 32'(bus.empty), 32'd1);

        // Wrap with the writer kept ahead
        do_reset();
        step(1'b0, 4'd4);
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, w_cnt + 4'd1);
            if (i == 8) begin
                check_val("wrap8_rptr", 32'(bus.rptr), 32'b1100);
                check_val("wrap8_raddr", 32'(bus.raddr), 32'd0);
            end
        end
        check_val("wrap16_rptr", 32'(bus.rptr), 32'd0);

        // Read and write in the same cycle, then reset mid-operation
        step(1'b1, w_cnt + 4'd1);
        check_val("simul_level", 32'(bus.rd_level), 32'd4);
        step(1'b0, w_cnt + 4'd1);
        check_val("pre_rst_level", 32'(bus.rd_level), 32'd5);
        do_reset();
        step(1'b0, 4'd2);
        check_val("resume_raddr", 32'(bus.raddr), 32'd0);
        step(1'b1, 4'd2);
        check_val("resume_next", 32'(bus.raddr), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
